// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: symbolic requests in, packed words plus target addresses out via a 2-entry FIFO.
// Optional immediate range checking is built when RV_ENC_RANGE_CHECK_EN is defined.
module rv_instr_encoder #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  typedef enum logic [2:0] {
    K_LW   = 3'd0,
    K_SW   = 3'd1,
    K_R    = 3'd2,
    K_BEQ  = 3'd3,
    K_IALU = 3'd4,
    K_JAL  = 3'd5,
    K_LUI  = 3'd6,
    K_NOP  = 3'd7
  } kind_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  kind_e             kind;
  logic              is_shift;
  logic [31:0]       enc_word;
  logic              range_err;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] entry_addr;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        count_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  entry_t            mem_q [2];
  entry_t            head;

  assign kind     = kind_e'(in_kind);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (kind)
      K_LW:   enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      K_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      K_R:    enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      K_BEQ:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                          in_imm[4:1], in_imm[11], 7'b1100011};
      K_IALU: begin
        if (is_shift)
          enc_word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      K_JAL:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      K_LUI:  enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      default: enc_word = 32'h0000_0000;
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  // A signed value fits in N bits when all bits from N-1 upward agree.
  logic fits12;
  logic fits13;
  logic fits21;
  assign fits12 = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) || (~|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) || (~|in_imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (kind)
      K_LW, K_SW: range_err = !fits12;
      K_IALU:     range_err = is_shift ? (|in_imm[31:5]) : !fits12;
      K_BEQ:      range_err = !fits13 || in_imm[0];
      K_JAL:      range_err = !fits21 || in_imm[0];
      K_LUI:      range_err = |in_imm[11:0];
      default:    range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // Handshake flags depend only on stored occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign entry_addr = addr_load ? load_addr : addr_q;
  assign addr_d     = push ? entry_addr + ADDR_W'(4) : entry_addr;

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= RESET_ADDR;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the two-entry storage is reset too; it is tiny and this keeps the head value defined after reset.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      addr_q <= addr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{instr: enc_word, addr: entry_addr, err: range_err};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs read zero while empty so stale entries never appear on the bus.
  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head.instr : 32'h0000_0000;
  assign out_addr  = out_valid ? head.addr  : '0;
  assign err       = out_valid && head.err;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed, table-driven bench for rv_instr_encoder with hand-computed encodings,
// plus sequences for stall, address load/wrap and mid-queue reset.
module tb_rv_instr_encoder;

  localparam int AW = 32;
`ifdef RV_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic          in_funct7b5;
  logic [31:0]   in_imm;
  logic          addr_load;
  logic [AW-1:0] load_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;

  rv_instr_encoder #(.ADDR_W(AW), .RESET_ADDR('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_kind     (in_kind),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_imm      (in_imm),
    .addr_load   (addr_load),
    .load_addr   (load_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;   // meaningful only when range checking is built
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_kind     = v.kind;
    in_rd       = v.rd;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_funct3   = v.f3;
    in_funct7b5 = v.f7;
    in_imm      = v.imm;
    in_valid    = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] a0;
    vec_t v_lui;
    vec_t v_jal;
    vec_t v_li;
    vec_t v_nop;

    //            kind  rd     rs1    rs2    f3    f7    imm            instr          err
    vecs[0]  = '{3'd0, 5'd5,  5'd2,  5'd0,  3'd0, 1'b0, 32'd8,         32'h0081_2283, 1'b0}; // lw
    vecs[1]  = '{3'd2, 5'd3,  5'd1,  5'd2,  3'd0, 1'b0, 32'd0,         32'h0020_81B3, 1'b0}; // add
    vecs[2]  = '{3'd3, 5'd0,  5'd1,  5'd2,  3'd0, 1'b0, -32'sd4,       32'hFE20_8EE3, 1'b0}; // beq -4
    vecs[3]  = '{3'd1, 5'd0,  5'd2,  5'd5,  3'd0, 1'b0, 32'd12,        32'h0051_2623, 1'b0}; // sw
    vecs[4]  = '{3'd2, 5'd1,  5'd2,  5'd3,  3'd0, 1'b1, 32'd0,         32'h4031_00B3, 1'b0}; // sub
    vecs[5]  = '{3'd4, 5'd4,  5'd4,  5'd0,  3'd5, 1'b1, 32'd3,         32'h4032_5213, 1'b0}; // srai
    vecs[6]  = '{3'd4, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0}; // addi -1
    vecs[7]  = '{3'd1, 5'd0,  5'd2,  5'd1,  3'd0, 1'b0, -32'sd4,       32'hFE11_2E23, 1'b0}; // sw -4
    vecs[8]  = '{3'd5, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, -32'sd8,       32'hFF9F_F06F, 1'b0}; // jal -8
    vecs[9]  = '{3'd7, 5'd9,  5'd9,  5'd9,  3'd7, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0}; // nop
    vecs[10] = '{3'd6, 5'd10, 5'd0,  5'd0,  3'd0, 1'b0, 32'hFFFF_F000, 32'hFFFF_F537, 1'b0}; // lui
    vecs[11] = '{3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'd2048,      32'h8000_0013, 1'b1}; // addi 2048
    vecs[12] = '{3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'd2047,      32'h7FF0_0013, 1'b0}; // addi 2047
    vecs[13] = '{3'd3, 5'd0,  5'd1,  5'd2,  3'd0, 1'b0, -32'sd3,       32'hFE20_8EE3, 1'b1}; // beq odd
    vecs[14] = '{3'd6, 5'd5,  5'd0,  5'd0,  3'd0, 1'b0, 32'h1234_5001, 32'h1234_52B7, 1'b1}; // lui low bits
    vecs[15] = '{3'd4, 5'd1,  5'd1,  5'd0,  3'd1, 1'b0, 32'd32,        32'h0000_9093, 1'b1}; // slli 32
    vecs[16] = '{3'd5, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'h0010_0000, 32'h8000_00EF, 1'b1}; // jal too far
    vecs[17] = '{3'd2, 5'd5,  5'd6,  5'd7,  3'd7, 1'b0, 32'd0,         32'h0073_72B3, 1'b0}; // and

    v_lui = '{3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    v_jal = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,         32'h0080_00EF, 1'b0};
    v_li  = vecs[6];
    v_nop = vecs[9];

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_load = 1'b0; load_addr = '0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst out_instr", out_instr,      32'd0);
    check("rst out_addr",  out_addr,       32'd0);
    check("rst err",       32'(err),       32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_addr = '0;

    // Back-to-back stream, one word per cycle.
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'd1);
      check($sformatf("v%0d instr", i),     out_instr,      vecs[i].exp_instr);
      check($sformatf("v%0d addr", i),      out_addr,       exp_addr);
      check($sformatf("v%0d err", i),       32'(err),       32'(vecs[i].exp_err & RC));
      exp_addr += 4;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Stall: fill the FIFO, verify backpressure and hold-stable head, then drain in order.
    out_ready = 1'b0;
    a0 = exp_addr;
    apply(v_lui);
    @(negedge clk);
    check("stall1 in_ready", 32'(in_ready), 32'd1);
    check("stall1 instr",    out_instr,     v_lui.exp_instr);
    apply(v_jal);
    @(negedge clk);
    check("stall2 in_ready", 32'(in_ready), 32'd0);
    check("stall2 instr",    out_instr,     v_lui.exp_instr);
    check("stall2 addr",     out_addr,      a0);
    apply(v_li);
    @(negedge clk);
    check("stall3 in_ready", 32'(in_ready), 32'd0);
    check("stall3 instr",    out_instr,     v_lui.exp_instr);
    check("stall3 addr",     out_addr,      a0);
    out_ready = 1'b1;
    @(negedge clk);
    // Full at the edge: pop happened but the third request was refused.
    check("rel1 instr",    out_instr,     v_jal.exp_instr);
    check("rel1 addr",     out_addr,      a0 + 4);
    check("rel1 in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("rel2 instr", out_instr, v_li.exp_instr);
    check("rel2 addr",  out_addr,  a0 + 8);
    in_valid = 1'b0;
    @(negedge clk);
    check("rel drain out_valid", 32'(out_valid), 32'd0);

    // Address load coinciding with a request, then load alone, then wrap.
    addr_load = 1'b1; load_addr = 32'h0000_0100;
    apply(v_nop);
    @(negedge clk);
    check("ld nop addr",  out_addr,  32'h0000_0100);
    check("ld nop instr", out_instr, 32'h0000_0000);
    addr_load = 1'b0;
    apply(vecs[1]);
    @(negedge clk);
    check("ld next addr", out_addr, 32'h0000_0104);
    addr_load = 1'b1; load_addr = 32'hFFFF_FFFC;
    apply(vecs[1]);
    @(negedge clk);
    check("ld top addr", out_addr, 32'hFFFF_FFFC);
    addr_load = 1'b0;
    apply(vecs[0]);
    @(negedge clk);
    check("wrap addr",  out_addr,  32'h0000_0000);
    check("wrap instr", out_instr, vecs[0].exp_instr);
    in_valid = 1'b0;
    addr_load = 1'b1; load_addr = 32'h0000_0200;
    @(negedge clk);
    addr_load = 1'b0;
    apply(vecs[3]);
    @(negedge clk);
    check("ld idle addr", out_addr, 32'h0000_0200);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset with two entries queued.
    out_ready = 1'b0;
    apply(vecs[0]);
    @(negedge clk);
    apply(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-rst in_ready",  32'(in_ready),  32'd0);
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready",  32'(in_ready),  32'd1);
    check("midrst out_instr", out_instr,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    apply(vecs[3]);
    @(negedge clk);
    check("post-rst addr",  out_addr,  32'h0000_0000);
    check("post-rst instr", out_instr, vecs[3].exp_instr);
    in_valid = 1'b0;
    @(negedge clk);
    check("post-rst drain", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the main control decoder: takes symbolic instruction requests (class, register fields, funct bits, full-width immediate) and emits packed RV32I instruction words with a target instruction-memory address.
- Feeds the boot/program-load path that fills instruction memory before or while the core runs.
- Covers the same instruction subset the core decodes: lw, sw, R-type, beq, I-type ALU, jal, lui, and the all-zero nop/reset word.
- Valid/ready handshake on both sides, with a 2-entry output FIFO between them.

Parameters:
- ADDR_W, 32, width of the address counter and out_addr.
- RESET_ADDR, 0, address counter value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_kind  in  3  instruction class: 0 lw, 1 sw, 2 R-type, 3 beq, 4 I-ALU, 5 jal, 6 lui, 7 nop.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field; used for R-type and I-ALU only.
- in_funct7b5  in  1  instruction bit 30; used for R-type and for shifts in I-ALU.
- in_imm  in  32  signed byte immediate/offset; for lui, the full 32-bit value.
- addr_load  in  1  load the address counter.
- load_addr  in  ADDR_W  value loaded when addr_load is asserted.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_instr  out  32  encoded instruction word.
- out_addr  out  ADDR_W  instruction-memory byte address for out_instr.
- err  out  1  head entry flagged as immediate out of range.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO is emptied.
  - out_valid=0, out_instr=0, out_addr=0, err=0.
  - Address counter = RESET_ADDR.
  - A reset that arrives mid-transfer discards all queued entries.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !full. It is registered-state only and has no combinational path from out_ready.
  - out_valid = !empty. out_instr, out_addr and err come from the head entry and must stay stable while out_valid && !out_ready.
- Latency:
  - A request accepted at edge N is visible at the outputs after edge N; one cycle minimum.
  - Throughput is 1 word per cycle when out_ready is held high.
- FIFO depth is 2:
  - Simultaneous push and pop when the FIFO holds 1 entry keeps the count at 1, and output order is preserved.
  - When the FIFO is full, in_ready=0 even if a pop is happening in the same cycle.
- Address counter:
  - On an accepted request, the entry captures the counter value and the counter advances by 4.
  - Wraps modulo 2^ADDR_W.
  - addr_load has priority. If addr_load coincides with an accepted request, that entry takes load_addr and the counter becomes load_addr+4.
- Encoding, with field positions per RV32I:
  - lw: imm[11:0], rs1, 010, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R-type: 0, funct7b5, 00000, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011. imm[0] is ignored.
  - I-ALU: imm[11:0], rs1, funct3, rd, 0010011. When funct3 is 001 or 101, bits 31:25 = 0, funct7b5, 00000 and bits 24:20 = imm[4:0].
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
  - lui: imm[31:12], rd, 0110111.
  - nop: 32'h00000000.
  - Fields unused by a class are ignored.
- Immediate bits outside the encodable field are silently truncated unless the optional feature below is enabled.

Optional Feature:
- Macro: RV_ENC_RANGE_CHECK_EN.
- Defined: err is computed at acceptance and travels with the entry. It is set when:
  - lw, sw or I-ALU: in_imm is not in -2048..2047 (shift forms: in_imm not in 0..31).
  - beq: in_imm is not in -4096..4094 or is odd.
  - jal: in_imm is not in -1048576..1048574 or is odd.
  - lui: in_imm[11:0] != 0.
- With err set, the word is still emitted, truncated as usual.
- Undefined: err is tied to 0 and no checking logic is built.

Test Plan:
- Reset, then lw rd=5 rs1=2 imm=8 with out_ready=1 -> one cycle later out_valid=1, out_instr=0x00812283, out_addr=0x0.
- Back-to-back add rd=3 rs1=1 rs2=2 funct3=0 funct7b5=0, then beq rs1=1 rs2=2 imm=-4 -> 0x002081B3 @0x0, then 0xFE208EE3 @0x4, one word per cycle.
- Hold out_ready=0 and send lui rd=5 imm=0x12345000 and jal rd=1 imm=8 -> in_ready drops after 2 accepts, outputs stay stable; releasing out_ready yields 0x123452B7 then 0x008000EF in order.
- addr_load=1 with load_addr=0x100 in the same cycle as a nop request -> entry has out_addr=0x100 and out_instr=0; the next request gets 0x104. Also load 0xFFFFFFFC with ADDR_W=32 -> the following entry wraps to 0x0.
- Assert reset while 2 entries are queued -> out_valid=0 immediately, in_ready=1, and the next request gets out_addr=RESET_ADDR.
- With RV_ENC_RANGE_CHECK_EN: addi funct3=000 imm=2048 -> err=1, out_instr=0x80000013 for rd=rs1=0. Odd beq offset -> err=1. imm=2047 -> err=0.
